// File: rtl/cc_sortseq_pkg.sv
// Shared definitions for the sort sequencer: state encoding, index width and compare-count helpers.
package cc_sortseq_pkg;

  typedef enum logic [1:0] {
    StLoad  = 2'b00,
    StSort  = 2'b01,
    StDrain = 2'b10
  } sortseq_state_e;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultIdxW  = $clog2(DefaultDepth);

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Worst-case number of compare cycles for one block.
  function automatic int unsigned compare_count(input int unsigned depth);
    return (depth * (depth - 1)) / 2;
  endfunction

endpackage

// File: rtl/cc_lessthan.sv
// Parameterized unsigned strict less-than comparator; the sorter's only arithmetic resource.
module cc_lessthan #(
  parameter int unsigned NUMBER_DATAWIDTH = 8
) (
  input  logic [NUMBER_DATAWIDTH-1:0] a_i,
  input  logic [NUMBER_DATAWIDTH-1:0] b_i,
  output logic                        lt_o
);

  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/cc_sort_sequencer.sv
// Load / bubble-sort / drain sequencer sharing one comparator across a register bank.
// Build option CC_SORTSEQ_EARLYEXIT_EN ends the sort after the first pass with no swap.
module cc_sort_sequencer
  import cc_sortseq_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH = 8,
  parameter int unsigned NUMBER_DEPTH     = 8
) (
  input  logic                        CC_SORTSEQ_CLOCK_50,
  input  logic                        CC_SORTSEQ_RESET_InLow,
  input  logic                        CC_SORTSEQ_inValid_In,
  output logic                        CC_SORTSEQ_inReady_Out,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_SORTSEQ_data_InBUS,
  output logic                        CC_SORTSEQ_outValid_Out,
  input  logic                        CC_SORTSEQ_outReady_In,
  output logic [NUMBER_DATAWIDTH-1:0] CC_SORTSEQ_data_OutBUS,
  output logic                        CC_SORTSEQ_outLast_Out,
  output logic                        CC_SORTSEQ_busy_Out
);

  localparam int unsigned IdxW = idx_width(NUMBER_DEPTH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUMBER_DEPTH - 1);
  localparam logic [IdxW-1:0] LastPass = IdxW'(NUMBER_DEPTH - 2);

  sortseq_state_e              state_q;
  logic [NUMBER_DATAWIDTH-1:0] bank_q [NUMBER_DEPTH];
  logic [IdxW-1:0]             wr_idx_q;
  logic [IdxW-1:0]             rd_idx_q;
  logic [IdxW-1:0]             pass_q;
  logic [IdxW-1:0]             idx_q;
  logic                        swapped_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [NUMBER_DATAWIDTH-1:0] data_out_q;
  logic                        out_last_q;
  logic                        busy_q;

  logic [NUMBER_DATAWIDTH-1:0] cmp_a;
  logic [NUMBER_DATAWIDTH-1:0] cmp_b;
  logic                        cmp_lt;
  logic                        pass_end;
  logic                        early_exit;

  assign cmp_a    = bank_q[idx_q + 1'b1];
  assign cmp_b    = bank_q[idx_q];
  assign pass_end = (idx_q == (LastPass - pass_q));

`ifdef CC_SORTSEQ_EARLYEXIT_EN
  // The current compare counts toward the pass's swap flag.
  assign early_exit = ~(swapped_q | cmp_lt);
`else
  assign early_exit = 1'b0;
`endif

  cc_lessthan #(
    .NUMBER_DATAWIDTH (NUMBER_DATAWIDTH)
  ) u_lessthan (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .lt_o (cmp_lt)
  );

  always_ff @(posedge CC_SORTSEQ_CLOCK_50 or negedge CC_SORTSEQ_RESET_InLow) begin
    if (!CC_SORTSEQ_RESET_InLow) begin
      state_q     <= StLoad;
      for (int i = 0; i < NUMBER_DEPTH; i++) bank_q[i] <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      pass_q      <= '0;
      idx_q       <= '0;
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          in_ready_q <= 1'b1;
          if (CC_SORTSEQ_inValid_In && in_ready_q) begin
            bank_q[wr_idx_q] <= CC_SORTSEQ_data_InBUS;
            if (wr_idx_q == LastIdx) begin
              state_q    <= StSort;
              wr_idx_q   <= '0;
              pass_q     <= '0;
              idx_q      <= '0;
              swapped_q  <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end

        StSort: begin
          if (cmp_lt) begin
            bank_q[idx_q]        <= cmp_a;
            bank_q[idx_q + 1'b1] <= cmp_b;
          end
          if (pass_end) begin
            if ((pass_q == LastPass) || early_exit) begin
              state_q     <= StDrain;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              rd_idx_q    <= '0;
              // Present the post-swap smallest word on the first drain cycle.
              data_out_q  <= (idx_q == '0 && cmp_lt) ? cmp_a : bank_q[0];
              out_last_q  <= 1'b0;
            end else begin
              pass_q    <= pass_q + 1'b1;
              idx_q     <= '0;
              swapped_q <= 1'b0;
            end
          end else begin
            idx_q     <= idx_q + 1'b1;
            swapped_q <= swapped_q | cmp_lt;
          end
        end

        StDrain: begin
          if (out_valid_q && CC_SORTSEQ_outReady_In) begin
            if (rd_idx_q == LastIdx) begin
              state_q     <= StLoad;
              rd_idx_q    <= '0;
              wr_idx_q    <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              data_out_q  <= '0;
              in_ready_q  <= 1'b1;
            end else begin
              rd_idx_q   <= rd_idx_q + 1'b1;
              data_out_q <= bank_q[rd_idx_q + 1'b1];
              out_last_q <= ((rd_idx_q + 1'b1) == LastIdx);
            end
          end
        end

        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

  assign CC_SORTSEQ_inReady_Out  = in_ready_q;
  assign CC_SORTSEQ_outValid_Out = out_valid_q;
  assign CC_SORTSEQ_data_OutBUS  = data_out_q;
  assign CC_SORTSEQ_outLast_Out  = out_last_q;
  assign CC_SORTSEQ_busy_Out     = busy_q;

endmodule
